// File: rtl/vs_pkg.sv
// Shared definitions for the VS1003 serial link: opcodes, register addresses,
// arbiter state encoding, select encoding and the SCI command word layout.
package vs_pkg;

    localparam int unsigned VS_WORD_W  = 32;
    localparam int unsigned VS_RDATA_W = 16;
    localparam int unsigned VS_BIT_W   = 5;
    localparam int unsigned VS_CNT_W   = 8;

    localparam logic [7:0] VS_OP_WRITE = 8'h02;
    localparam logic [7:0] VS_OP_READ  = 8'h03;

    localparam logic [7:0] VS_MODE = 8'h00;
    localparam logic [7:0] VS_VOL  = 8'h0B;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } vs_state_e;

    typedef enum logic {
        SEL_SCI = 1'b0,
        SEL_SDI = 1'b1
    } vs_sel_e;

    // SCI command word as presented on sci_word
    typedef struct packed {
        logic [7:0]  opcode;
        logic [7:0]  addr;
        logic [15:0] data;
    } vs_sci_word_t;

    function automatic logic vs_is_read(input logic [7:0] opcode);
        return opcode == VS_OP_READ;
    endfunction

endpackage

// File: rtl/vs_sclk_gen.sv
// SCLK generator for the VS1003 link.
// Divides CLK so SCLK toggles every CLK_DIV cycles while run is high; SCLK is
// forced low and the divider cleared whenever run is low.
// Ports:
//   CLK, RST  - system clock, synchronous active-high reset
//   run       - enable; high only while a word is being shifted
//   sclk      - registered serial clock
//   rise_c    - combinational strobe: sclk goes 0->1 on this edge
//   fall_c    - combinational strobe: sclk goes 1->0 on this edge
module vs_sclk_gen
    import vs_pkg::*;
#(
    parameter int unsigned CLK_DIV = 50
) (
    input  logic CLK,
    input  logic RST,
    input  logic run,
    output logic sclk,
    output logic rise_c,
    output logic fall_c
);

    logic [VS_CNT_W-1:0] divcnt;
    logic                wrap_c;

    // Half-period boundary
    assign wrap_c = run && (divcnt == VS_CNT_W'(CLK_DIV - 1));
    assign rise_c = wrap_c && !sclk;
    assign fall_c = wrap_c && sclk;

    // Divider and SCLK register; idle low outside a word
    always_ff @(posedge CLK) begin
        if (RST || !run) begin
            divcnt <= '0;
            sclk   <= 1'b0;
        end else if (wrap_c) begin
            divcnt <= '0;
            sclk   <= ~sclk;
        end else begin
            divcnt <= divcnt + VS_CNT_W'(1);
        end
    end

endmodule

// File: rtl/vs_spi_arbiter.sv
// Arbiter and serializer for the single VS1003 serial link.
// Grants whole 32-bit words to either the SCI command requester (strict
// priority) or the SDI stream requester, gated by the resynchronized DREQ.
// Owns chip-select, SCLK generation and bit shifting; a word is never
// preempted once granted.
// Ports:
//   CLK, RST              - system clock, synchronous active-high reset
//   sci_valid/word/ready  - command word handshake {opcode, addr, data}
//   sci_rdata, sci_done   - read data and completion pulse for commands
//   sdi_valid/word/ready  - audio stream word handshake
//   MP3_CS, MP3_DCS       - SCI / SDI selects, active low
//   MP3_SCLK, MP3_MOSI    - serial clock and data out
//   MP3_MISO              - serial data in
//   MP3_DREQ              - decoder ready, asynchronous
//   busy                  - high whenever the FSM is not idle
module vs_spi_arbiter
    import vs_pkg::*;
#(
    parameter int unsigned CLK_DIV = 50,
    parameter int unsigned GAP_CYC = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  sci_valid,
    input  logic [VS_WORD_W-1:0]  sci_word,
    output logic                  sci_ready,
    output logic [VS_RDATA_W-1:0] sci_rdata,
    output logic                  sci_done,
    input  logic                  sdi_valid,
    input  logic [VS_WORD_W-1:0]  sdi_word,
    output logic                  sdi_ready,
    output logic                  MP3_CS,
    output logic                  MP3_DCS,
    output logic                  MP3_SCLK,
    output logic                  MP3_MOSI,
    input  logic                  MP3_MISO,
    input  logic                  MP3_DREQ,
    output logic                  busy
);

    vs_state_e             state;
    vs_sel_e               sel;
    logic                  op_read;
    logic [VS_WORD_W-1:0]  shreg;
    logic [VS_RDATA_W-1:0] rx;
    logic [VS_BIT_W-1:0]   bitcnt;
    logic [VS_CNT_W-1:0]   gapcnt;
    logic                  dreq_meta;
    logic                  dreq_s;
    logic                  sclk_run_c;
    logic                  sclk_rise_c;
    logic                  sclk_fall_c;

    // Two-flop resynchronizer for the asynchronous DREQ pin
    always_ff @(posedge CLK) begin
        if (RST) begin
            dreq_meta <= 1'b0;
            dreq_s    <= 1'b0;
        end else begin
            dreq_meta <= MP3_DREQ;
            dreq_s    <= dreq_meta;
        end
    end

    assign sclk_run_c = (state == ST_SHIFT);

    vs_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .CLK    (CLK),
        .RST    (RST),
        .run    (sclk_run_c),
        .sclk   (MP3_SCLK),
        .rise_c (sclk_rise_c),
        .fall_c (sclk_fall_c)
    );

    // Arbitration, framing and shifting FSM with registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            sel       <= SEL_SCI;
            op_read   <= 1'b0;
            shreg     <= '0;
            rx        <= '0;
            bitcnt    <= '0;
            gapcnt    <= '0;
            sci_ready <= 1'b0;
            sdi_ready <= 1'b0;
            sci_done  <= 1'b0;
            sci_rdata <= '0;
            MP3_CS    <= 1'b1;
            MP3_DCS   <= 1'b1;
            MP3_MOSI  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            sci_ready <= 1'b0;
            sdi_ready <= 1'b0;
            sci_done  <= 1'b0;

            case (state)
                ST_IDLE: begin
                    // SCI wins whenever both requesters are pending
                    if (dreq_s && sci_valid) begin
                        sci_ready <= 1'b1;
                        shreg     <= sci_word;
                        sel       <= SEL_SCI;
                        op_read   <= vs_is_read(sci_word[31:24]);
                        busy      <= 1'b1;
                        state     <= ST_LOAD;
                    end else if (dreq_s && sdi_valid) begin
                        sdi_ready <= 1'b1;
                        shreg     <= sdi_word;
                        sel       <= SEL_SDI;
                        op_read   <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    if (sel == SEL_SCI) begin
                        MP3_CS <= 1'b0;
                    end else begin
                        MP3_DCS <= 1'b0;
                    end
                    MP3_MOSI <= shreg[31];
                    bitcnt   <= '0;
                    state    <= ST_SHIFT;
                end

                ST_SHIFT: begin
                    // Read data occupies the second half of an SCI word
                    if (sclk_rise_c && bitcnt[4]) begin
                        rx <= {rx[VS_RDATA_W-2:0], MP3_MISO};
                    end
                    // MOSI only moves on the falling edge, while SCLK is low
                    if (sclk_fall_c) begin
                        if (bitcnt == VS_BIT_W'(31)) begin
                            MP3_CS  <= 1'b1;
                            MP3_DCS <= 1'b1;
                            gapcnt  <= '0;
                            state   <= ST_GAP;
                            if (sel == SEL_SCI) begin
                                sci_done <= 1'b1;
                                if (op_read) begin
                                    sci_rdata <= rx;
                                end
                            end
                        end else begin
                            bitcnt   <= bitcnt + VS_BIT_W'(1);
                            shreg    <= {shreg[VS_WORD_W-2:0], 1'b0};
                            MP3_MOSI <= shreg[VS_WORD_W-2];
                        end
                    end
                end

                ST_GAP: begin
                    if (gapcnt == VS_CNT_W'(GAP_CYC - 1)) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        gapcnt <= gapcnt + VS_CNT_W'(1);
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/vs_spi_arbiter.md
# vs_spi_arbiter

Shares the single VS1003 serial link (MOSI/MISO/SCLK, DREQ) between a command requester (SCI register writes and reads, e.g. mode and volume) and a stream requester (SDI 32-bit audio words from ROM). It sits between the playback sequencer and the MP3 pins. It owns chip-select generation, SCLK generation, DREQ gating and bit shifting, so upstream logic only exchanges whole words over valid/ready.

## Interface
- `CLK_DIV`, default 50: CLK cycles per SCLK half-period; legal range 1..255.
- `GAP_CYC`, default 4: minimum CLK cycles with both selects high between transfers; legal range 1..255.
- `CLK` in 1: system clock.
- `RST` in 1: reset, **synchronous, active-high**.
- `sci_valid` in 1: command word pending.
- `sci_word` in 32: `{opcode[7:0], addr[7:0], data[15:0]}`. Opcode 0x02 is a write, 0x03 a read.
- `sci_ready` out 1: command accepted this cycle.
- `sci_rdata` out 16: read data. Valid in the cycle `sci_done` is high and held until the next read completes.
- `sci_done` out 1: one-cycle pulse when the command transfer finishes.
- `sdi_valid` in 1: stream word pending.
- `sdi_word` in 32: audio bytes, MSB first.
- `sdi_ready` out 1: stream word accepted this cycle.
- `MP3_CS` out 1: SCI select, active low.
- `MP3_DCS` out 1: SDI select, active low.
- `MP3_SCLK` out 1: serial clock.
- `MP3_MOSI` out 1: serial data out.
- `MP3_MISO` in 1: serial data in.
- `MP3_DREQ` in 1: decoder can accept data. Asynchronous; the block resynchronizes it.
- `busy` out 1: high in every state except IDLE.

## Operation
- DREQ passes through a 2-flop synchronizer. `dreq_s` denotes the synchronized value.
- State machine: IDLE, LOAD, SHIFT, GAP.
- **IDLE**
  - Grant SCI when `sci_valid && dreq_s`.
  - Otherwise grant SDI when `sdi_valid && dreq_s`.
  - SCI has strict priority. The arbiter never preempts a word in flight.
  - On grant: pulse the matching `*_ready` for 1 cycle, latch the word into the 32-bit shift register, record `sel` (SCI or SDI), go to LOAD.
- **LOAD**
  - Assert the selected select low (`MP3_CS` or `MP3_DCS`).
  - Drive `MP3_MOSI` = shreg[31].
  - Clear `bitcnt` to 0 and `divcnt` to 0.
  - Go to SHIFT.
- **SHIFT**
  - `divcnt` counts 0..CLK_DIV-1. On wrap, toggle SCLK.
  - On the rising edge (SCLK 0→1): sample `MP3_MISO` into `rx[15:0]` (shift left) when `bitcnt >= 16`.
  - On the falling edge (SCLK 1→0): if `bitcnt == 31`, go to GAP. Otherwise increment `bitcnt`, shift shreg left, drive the new MSB on MOSI.
  - DREQ is ignored inside a word.
- **GAP**
  - Deassert both selects, hold SCLK 0.
  - Count GAP_CYC cycles, then go to IDLE.
  - On GAP entry with `sel == SCI`: pulse `sci_done`, and if the opcode was 0x03, load `sci_rdata <= rx`.
- Exactly 32 SCLK rising edges per word. SCLK idles low. MOSI changes only while SCLK is low.
- `MP3_CS` and `MP3_DCS` are never low at the same time.
- Reset values: `MP3_CS`=1, `MP3_DCS`=1, `MP3_SCLK`=0, `MP3_MOSI`=0, `sci_ready`=0, `sdi_ready`=0, `sci_done`=0, `sci_rdata`=0, `busy`=0, state=IDLE, synchronizer flops=0.
- Reset in mid-word: all outputs return to reset values on the next edge. The partial word is dropped and not retried; `sci_done` does not pulse.
- DREQ falling in IDLE: no grant until it returns high.
- Both valids high with DREQ high: SCI wins. SDI waits at least one full word plus the gap.

## Timing
- Grant to select low: 1 cycle (IDLE→LOAD edge).
- First SCLK rise: CLK_DIV cycles after entering SHIFT.
- Word duration in SHIFT: 64·CLK_DIV cycles.
- Total per word: 1 + 1 + 64·CLK_DIV + GAP_CYC cycles.
- With defaults (100 MHz CLK, 1 MHz SCLK): 3206 cycles per word.
- DREQ-to-grant latency: 2 cycles of synchronizer plus 1.
- `*_ready` and `sci_done` are single-cycle pulses, registered.

## Structure
- Shared package `vs_pkg`:
  - Opcodes `VS_OP_WRITE`=8'h02, `VS_OP_READ`=8'h03.
  - Register addresses `VS_MODE`=8'h00, `VS_VOL`=8'h0B.
  - State enum.
  - Select encoding `SEL_SCI` / `SEL_SDI`.
- One sub-module: `vs_sclk_gen`. It holds `divcnt`, the SCLK register, and rise/fall strobes, and is parameterized by CLK_DIV.
- The FSM, shift register and arbitration stay in the top.

## Test plan
- **SCI write:** `sci_word`=32'h020B_F0F0, DREQ=1, CLK_DIV=2 → `MP3_CS` low for 128 cycles; MOSI bits sampled on SCLK rises equal 0x020BF0F0 MSB first; `MP3_DCS` stays 1; `sci_done` pulses once.
- **SCI read:** `sci_word`=32'h0300_0000, MISO model returns 16'h0804 during bits 16..31 → `sci_rdata`=16'h0804 in the `sci_done` cycle.
- **Priority:** both valid with DREQ=1 → SCI transfer first; SDI `sdi_ready` only after GAP_CYC idle cycles; selects never both low.
- **DREQ gating:** DREQ=0 with `sdi_valid`=1 → no `sdi_ready`, selects high. DREQ dropped mid-word → the word still completes with 32 edges, and no new grant until DREQ=1.
- **Reset mid-word:** `RST` pulsed after 10 SCLK rises → next cycle `MP3_CS`=1, `MP3_DCS`=1, SCLK=0, `busy`=0, no `sci_done`.
- **Streaming:** 4 back-to-back SDI words 0xFFFB9064, 0x00000000, 0xAAAA5555, 0x12345678 → 128 bits captured in order, gap ≥ GAP_CYC cycles between words.
